// File: rtl/phy_send.sv
`default_nettype none
// ============================================================================
// Module   : phy_send
// Brief    : Transmit framer. Adds preamble and SFD, pads short frames, and
//            enforces the inter-packet gap. Define PHY_SEND_FCS_EN to append
//            the Ethernet CRC-32 FCS.
// Revision : 1.0 - initial release
// ============================================================================
module phy_send #(
    parameter int MIN_PAYLOAD = 60,
    parameter int IFG_BYTES   = 12
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic [7:0] phy_tx_data,
    output logic       phy_tx_valid,
    output logic       busy,
    output logic       tx_underrun
);

    localparam logic [2:0]  c_st_idle     = 3'd0;
    localparam logic [2:0]  c_st_preamble = 3'd1;
    localparam logic [2:0]  c_st_sfd      = 3'd2;
    localparam logic [2:0]  c_st_payload  = 3'd3;
    localparam logic [2:0]  c_st_pad      = 3'd4;
    localparam logic [2:0]  c_st_ifg      = 3'd6;
`ifdef PHY_SEND_FCS_EN
    localparam logic [2:0]  c_st_fcs      = 3'd5;
    localparam logic [2:0]  c_st_post     = c_st_fcs;
`else
    localparam logic [2:0]  c_st_post     = c_st_ifg;
`endif

    localparam logic [7:0]  c_preamble_byte = 8'h55;
    localparam logic [7:0]  c_sfd_byte      = 8'hD5;
    localparam logic [10:0] c_count_max     = 11'h7FF;
    localparam logic [10:0] c_min_payload   = 11'(MIN_PAYLOAD);
    localparam logic [10:0] c_ifg_last      = 11'(IFG_BYTES - 1);

    logic [2:0]  r_state;
    logic [2:0]  r_pcnt;
    logic [10:0] r_count;
    logic [7:0]  r_phy_data;
    logic        r_phy_valid;
    logic        r_tx_ready;
    logic        r_busy;
    logic        r_underrun;

    logic        w_accept;
    logic [10:0] w_count_inc;

    assign w_accept    = r_tx_ready & tx_valid;
    assign w_count_inc = (r_count == c_count_max) ? r_count : r_count + 11'd1;

`ifdef PHY_SEND_FCS_EN
    logic [31:0] r_crc;
    logic [7:0]  w_fcs_byte;

    function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    assign w_fcs_byte = ~r_crc[7:0];

    // CRC is reloaded throughout the preamble so it holds the seed in the SFD
    // cycle; during FCS it shifts down so the low byte is always next out.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_crc <= 32'hFFFF_FFFF;
        end else begin
            case (r_state)
                c_st_preamble: r_crc <= 32'hFFFF_FFFF;
                c_st_sfd, c_st_payload: begin
                    if (w_accept) r_crc <= crc_next(r_crc, tx_data);
                end
                c_st_pad: r_crc <= crc_next(r_crc, 8'h00);
                c_st_fcs: r_crc <= {8'h00, r_crc[31:8]};
                default: r_crc <= r_crc;
            endcase
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= c_st_idle;
            r_pcnt      <= 3'd0;
            r_count     <= 11'd0;
            r_phy_data  <= 8'h00;
            r_phy_valid <= 1'b0;
            r_tx_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (tx_valid) begin
                        r_state     <= c_st_preamble;
                        r_phy_data  <= c_preamble_byte;
                        r_phy_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_pcnt      <= 3'd0;
                    end
                end
                c_st_preamble: begin
                    if (r_pcnt == 3'd6) begin
                        r_state    <= c_st_sfd;
                        r_phy_data <= c_sfd_byte;
                        r_tx_ready <= 1'b1;
                        r_count    <= 11'd0;
                    end else begin
                        r_phy_data <= c_preamble_byte;
                        r_pcnt     <= r_pcnt + 3'd1;
                    end
                end
                c_st_sfd, c_st_payload: begin
                    if (tx_valid) begin
                        r_phy_data <= tx_data;
                        r_count    <= w_count_inc;
                        r_state    <= c_st_payload;
                        if (tx_last) begin
                            r_tx_ready <= 1'b0;
                            r_pcnt     <= 3'd0;
                            if (w_count_inc < c_min_payload) begin
                                r_state <= c_st_pad;
                            end else begin
                                r_state <= c_st_post;
                                r_count <= 11'd0;
                            end
                        end
                    end else begin
                        // Upstream stalled: abandon the frame without pad or FCS.
                        r_phy_data  <= 8'h00;
                        r_phy_valid <= 1'b0;
                        r_tx_ready  <= 1'b0;
                        r_underrun  <= 1'b1;
                        r_count     <= 11'd0;
                        r_state     <= c_st_ifg;
                    end
                end
                c_st_pad: begin
                    r_phy_data <= 8'h00;
                    r_count    <= w_count_inc;
                    if (w_count_inc >= c_min_payload) begin
                        r_state <= c_st_post;
                        r_count <= 11'd0;
                        r_pcnt  <= 3'd0;
                    end
                end
`ifdef PHY_SEND_FCS_EN
                c_st_fcs: begin
                    r_phy_data <= w_fcs_byte;
                    r_pcnt     <= r_pcnt + 3'd1;
                    if (r_pcnt == 3'd3) begin
                        r_state <= c_st_ifg;
                        r_count <= 11'd0;
                    end
                end
`endif
                c_st_ifg: begin
                    r_phy_data  <= 8'h00;
                    r_phy_valid <= 1'b0;
                    r_count     <= r_count + 11'd1;
                    if (r_count == c_ifg_last) begin
                        r_state <= c_st_idle;
                        r_busy  <= 1'b0;
                        r_count <= 11'd0;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign tx_ready     = r_tx_ready;
    assign phy_tx_data  = r_phy_data;
    assign phy_tx_valid = r_phy_valid;
    assign busy         = r_busy;
    assign tx_underrun  = r_underrun;

endmodule
`default_nettype wire
